// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack crossing: holds a captured word on tx_data,
// drives tx_req, watches a synchronized tx_ack and aborts with a sticky error on timeout.
module cdc_handshake_tx #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [N-1:0] tx_data,
  output logic         tx_req,
  input  logic         tx_ack,
  output logic         done,
  output logic         timeout_err,
  input  logic         err_clr
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic             TO_EN    = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_REQ   = 2'd2,
    ST_REL   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N-1:0]         data_q, data_d;
  logic                 req_q, req_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 ack_s;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 expired;

  // tx_ack synchronizer; runs every cycle independent of ena
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tx_ack};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a matching ack level always beats a coincident timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = err_q & ~err_clr;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    expired = TO_EN & (cnt_q == CNT_LAST);

    if (ena) begin
      unique case (state_q)
        ST_IDLE: begin
          if (s_valid && s_ready) begin
            data_d  = s_data;
            state_d = ST_SETUP;
          end
        end
        ST_SETUP: begin
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
        ST_REQ: begin
          if (ack_s) begin
            req_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_REL;
          end else if (expired) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_REL: begin
          if (!ack_s) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (expired) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // New words are held off while the far side still reports ack
  assign s_ready     = ena & (state_q == ST_IDLE) & ~ack_s;
  assign tx_data     = data_q;
  assign tx_req      = req_q;
  assign done        = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: directed scenarios then random traffic, all checked
// every cycle against a phase-level model of the handshake.
`timescale 1ns/1ps
module tb_cdc_handshake_tx;

  localparam int N    = 8;
  localparam int SYNC = 2;
  localparam int TMO  = 16;

  localparam int PH_IDLE  = 0;
  localparam int PH_SETUP = 1;
  localparam int PH_REQ   = 2;
  localparam int PH_REL   = 3;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         ena     = 1'b1;
  logic [N-1:0] s_data  = '0;
  logic         s_valid = 1'b0;
  logic         tx_ack  = 1'b0;
  logic         err_clr = 1'b0;
  logic         s_ready;
  logic [N-1:0] tx_data;
  logic         tx_req;
  logic         done;
  logic         timeout_err;

  cdc_handshake_tx #(.N(N), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack),
    .done(done), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake model: a phase plus the cycles spent waiting for the awaited ack level
  int           phase     = PH_IDLE;
  int           elapsed   = 0;
  int           acc_count = 0;
  bit           model_on  = 1'b0;
  logic [N-1:0] m_data    = '0;
  bit           m_req     = 1'b0;
  bit           m_done    = 1'b0;
  bit           m_err     = 1'b0;
  bit           ackq[$];

  // tx_ack as seen SYNC edges later
  function automatic bit ack_seen();
    return (ackq.size() == SYNC) ? ackq[SYNC-1] : 1'b0;
  endfunction

  always @(posedge clk) begin
    bit a;
    a = ack_seen();
    if (rst) begin
      model_on = 1'b1;
      phase    = PH_IDLE;
      elapsed  = 0;
      m_data   = '0;
      m_req    = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      ackq.delete();
    end else begin
      m_done = 1'b0;
      if (err_clr) m_err = 1'b0;
      if (ena) begin
        case (phase)
          PH_IDLE: if (s_valid && !a) begin
            m_data = s_data;
            phase  = PH_SETUP;
            acc_count++;
          end
          PH_SETUP: begin
            m_req   = 1'b1;
            phase   = PH_REQ;
            elapsed = 0;
          end
          PH_REQ, PH_REL: begin
            if (a == (phase == PH_REQ)) begin
              if (phase == PH_REQ) begin
                m_req   = 1'b0;
                phase   = PH_REL;
                elapsed = 0;
              end else begin
                m_done = 1'b1;
                phase  = PH_IDLE;
              end
            end else if (TMO > 0 && elapsed + 1 >= TMO) begin
              m_err = 1'b1;
              m_req = 1'b0;
              phase = PH_IDLE;
            end else begin
              elapsed++;
            end
          end
          default: ;
        endcase
      end
      ackq.push_front(tx_ack);
      if (ackq.size() > SYNC) void'(ackq.pop_back());
    end
  end

  // Per-cycle compare against the model, on the falling edge
  logic [N-1:0] done_words[$];
  int           req_hi = 0;

  always @(negedge clk) begin
    if (model_on) begin
      chk("s_ready", 32'(s_ready), 32'(ena && phase == PH_IDLE && !ack_seen()));
      chk("tx_req", 32'(tx_req), 32'(m_req));
      chk("tx_data", 32'(tx_data), 32'(m_data));
      chk("done", 32'(done), 32'(m_done));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
      if (m_done) done_words.push_back(m_data);
      if (m_req) req_hi++;
    end
  end

  // Far side: mode 0 follows tx_req after resp_dly cycles, 1 never acks, 2 acks and never releases
  int resp_mode = 0;
  int resp_dly  = 0;
  int resp_wait = 0;

  always @(negedge clk) begin
    logic want;
    want = (tx_req === 1'b1);
    case (resp_mode)
      1: tx_ack = 1'b0;
      2: if (want) tx_ack = 1'b1;
      default: begin
        if (want != tx_ack) begin
          if (resp_wait >= resp_dly) begin
            tx_ack    = want;
            resp_wait = 0;
          end else begin
            resp_wait++;
          end
        end else begin
          resp_wait = 0;
        end
      end
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [N-1:0] w);
    int start;
    int k;
    start   = acc_count;
    k       = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (acc_count == start && k < 300) begin
      tick(1);
      k++;
    end
    chk("accept", 32'(acc_count != start), 32'd1);
  endtask

  task automatic wait_done(input int want, input string name);
    int k;
    k = 0;
    while (done_words.size() < want && k < 200) begin
      tick(1);
      k++;
    end
    chk(name, 32'(done_words.size()), 32'(want));
  endtask

  task automatic wait_err(input string name);
    int k;
    k = 0;
    while (!m_err && k < 100) begin
      tick(1);
      k++;
    end
    chk(name, 32'(m_err), 32'd1);
  endtask

  bit rnd_done = 1'b0;

  initial begin
    int base;
    int k;
    int acc0;

    // Reset for three edges with tx_ack low
    tick(3);
    rst = 1'b0;
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);

    // Single transfer
    base = done_words.size();
    send(8'hA5);
    s_valid = 1'b0;
    wait_done(base + 1, "a5_done");
    chk("a5_word", 32'(done_words[base]), 32'hA5);
    tick(3);
    chk("a5_once", 32'(done_words.size()), 32'(base + 1));
    chk("a5_ready", 32'(s_ready), 32'd1);

    // Back-to-back with s_valid held
    base = done_words.size();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    s_valid = 1'b0;
    wait_done(base + 3, "b2b_done");
    for (int i = 0; i < 3; i++)
      chk("b2b_word", 32'(done_words[base + i]), 32'(i + 1));

    // Stuck-low ack: timeout in REQ
    resp_mode = 1;
    req_hi    = 0;
    base      = done_words.size();
    send(8'h77);
    s_valid = 1'b0;
    wait_err("stuck_err_wait");
    tick(2);
    chk("stuck_err", 32'(timeout_err), 32'd1);
    chk("stuck_req", 32'(tx_req), 32'd0);
    chk("stuck_req_cycles", 32'(req_hi), 32'd16);
    chk("stuck_no_done", 32'(done_words.size()), 32'(base));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_clr", 32'(timeout_err), 32'd0);

    // Stuck-high ack: timeout in REL, accepts gated until ack falls
    resp_mode = 2;
    base      = done_words.size();
    send(8'h5A);
    s_valid = 1'b0;
    wait_err("hi_err_wait");
    acc0    = acc_count;
    s_data  = 8'h3C;
    s_valid = 1'b1;
    tick(5);
    chk("hi_blocked", 32'(s_ready), 32'd0);
    chk("hi_no_accept", 32'(acc_count), 32'(acc0));
    chk("hi_no_done", 32'(done_words.size()), 32'(base));
    resp_mode = 0;
    err_clr   = 1'b1;
    send(8'h3C);
    err_clr   = 1'b0;
    s_valid   = 1'b0;
    wait_done(base + 1, "hi_done");
    chk("hi_word", 32'(done_words[base]), 32'h3C);
    chk("hi_err_cleared", 32'(timeout_err), 32'd0);

    // ena low for five cycles while in REQ
    base = done_words.size();
    send(8'h96);
    s_valid = 1'b0;
    k = 0;
    while (!m_req && k < 20) begin
      tick(1);
      k++;
    end
    chk("frz_req_seen", 32'(m_req), 32'd1);
    ena = 1'b0;
    tick(5);
    chk("frz_req", 32'(tx_req), 32'd1);
    chk("frz_ready", 32'(s_ready), 32'd0);
    chk("frz_no_done", 32'(done_words.size()), 32'(base));
    ena = 1'b1;
    wait_done(base + 1, "frz_done");
    chk("frz_word", 32'(done_words[base]), 32'h96);

    // Reset pulse while in REL
    base = done_words.size();
    send(8'hC3);
    s_valid = 1'b0;
    k = 0;
    while (phase != PH_REL && k < 30) begin
      tick(1);
      k++;
    end
    chk("rel_seen", 32'(phase), 32'(PH_REL));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("relrst_req", 32'(tx_req), 32'd0);
    chk("relrst_data", 32'(tx_data), 32'd0);
    chk("relrst_ready", 32'(s_ready), 32'd1);
    tick(8);
    chk("relrst_no_done", 32'(done_words.size()), 32'(base));

    // Random traffic with ena/err_clr jitter and occasional slow far side
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          resp_dly = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
          tick(int'($urandom_range(0, 3)));
          send(N'($urandom));
          if ($urandom_range(0, 1) == 1) s_valid = 1'b0;
        end
        s_valid  = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          ena     = ($urandom_range(0, 7) != 0);
          err_clr = ($urandom_range(0, 15) == 0);
          tick(1);
        end
        ena     = 1'b1;
        err_clr = 1'b0;
      end
    join
    resp_dly = 0;
    tick(80);
    chk("final_idle", 32'(tx_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
